// File: rtl/rx_frame_arbiter_pkg.sv
// Shared types for the dual-port RGMII receive merger.
//   wrState_e   : per-port write FSM state (IDLE / INFRAME)
//   arbState_e  : read-side arbiter state (ARB / SEND)
//   frameWord_t : one stored word of frame data
package rx_frame_arbiter_pkg;

  typedef enum logic {
    WR_IDLE    = 1'b0,
    WR_INFRAME = 1'b1
  } wrState_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_SEND = 1'b1
  } arbState_e;

  typedef struct packed {
    logic [7:0] data;
  } frameWord_t;

endpackage

// File: rtl/rx_port_buffer.sv
// Store-and-forward buffer for one receive port.
// A write FSM stores bytes into a data RAM and commits the frame length into
// a small FIFO only when the frame ends cleanly. Errored, overflowing,
// truncated or link-lost frames are rewound and counted as drops.
// Ports:
//   clk125, rst               : clock, synchronous active-high reset
//   data/val/err/sof/eof      : incoming byte stream
//   linkUp                    : link status, input ignored while low
//   rdEn                      : read one byte at rdPtr (data valid next cycle)
//   lenPop                    : pop the head of the committed-length FIFO
//   len, empty                : head of the length FIFO, FIFO empty flag
//   rdData                    : registered RAM read data
//   dropCnt                   : saturating dropped-frame count
module rx_port_buffer
  import rx_frame_arbiter_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              val,
  input  logic              err,
  input  logic              sof,
  input  logic              eof,
  input  logic              linkUp,
  input  logic              rdEn,
  input  logic              lenPop,
  output logic [ADDR_W:0]   len,
  output logic              empty,
  output logic [7:0]        rdData,
  output logic [CNT_W-1:0]  dropCnt
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LEN_W:0]   LPTR_ONE = (LEN_W + 1)'(1);
  // A write is refused once the buffer already holds 2^ADDR_W-1 bytes, so
  // the write pointer can never catch the read pointer modulo the RAM depth.
  localparam logic [PTR_W-1:0] MAX_USED = {1'b0, {ADDR_W{1'b1}}};

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                              input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(inc);
    satAdd = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  frameWord_t          mem    [0:(1 << ADDR_W) - 1];
  logic [PTR_W-1:0]    lenMem [0:(1 << LEN_W) - 1];

  wrState_e            wrState, stateNxt;
  logic [PTR_W-1:0]    wrPtr, rdPtr, frameStart, frmLen;
  logic [PTR_W-1:0]    wrPtrNxt, startNxt, lenNxt, base, used;
  logic                errSeen, ovf, errNxt, ovfNxt, canWrite;
  logic                memWe, push, lenFull;
  logic [ADDR_W-1:0]   memAddr;
  logic [1:0]          dropInc;
  logic [LEN_W:0]      lenWr, lenRd;

  assign empty   = (lenWr == lenRd);
  assign lenFull = ((lenWr ^ lenRd) == {1'b1, {LEN_W{1'b0}}});
  assign len     = lenMem[lenRd[LEN_W-1:0]];

  always_comb begin
    stateNxt = wrState;
    wrPtrNxt = wrPtr;
    startNxt = frameStart;
    lenNxt   = frmLen;
    errNxt   = errSeen;
    ovfNxt   = ovf;
    memWe    = 1'b0;
    push     = 1'b0;
    dropInc  = 2'd0;
    base     = wrPtr;
    used     = '0;
    canWrite = 1'b0;
    memAddr  = wrPtr[ADDR_W-1:0];
    if (!linkUp) begin
      if (wrState == WR_INFRAME) begin
        wrPtrNxt = frameStart;
        dropInc  = 2'd1;
        stateNxt = WR_IDLE;
      end
    end else if (val && (sof || wrState == WR_INFRAME)) begin
      if (sof) begin
        // sof inside a frame: the unterminated frame is dropped and the new
        // one reuses its start position.
        if (wrState == WR_INFRAME) begin
          dropInc = 2'd1;
          base    = frameStart;
        end
        used     = base - rdPtr;
        canWrite = (used < MAX_USED);
        startNxt = base;
        lenNxt   = PTR_ONE;
        errNxt   = err;
        ovfNxt   = !canWrite;
      end else begin
        used     = wrPtr - rdPtr;
        canWrite = !ovf && (used < MAX_USED);
        lenNxt   = frmLen + PTR_ONE;
        errNxt   = errSeen | err;
        ovfNxt   = ovf | !canWrite;
      end
      memWe    = canWrite;
      memAddr  = base[ADDR_W-1:0];
      wrPtrNxt = canWrite ? base + PTR_ONE : base;
      stateNxt = WR_INFRAME;
      if (eof) begin
        stateNxt = WR_IDLE;
        if (!errNxt && !ovfNxt && !lenFull) begin
          push = 1'b1;
        end else begin
          wrPtrNxt = startNxt;
          dropInc  = dropInc + 2'd1;
        end
      end
    end else if (wrState == WR_INFRAME && err) begin
      errNxt = 1'b1;
    end
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      wrState    <= WR_IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      frameStart <= '0;
      frmLen     <= '0;
      errSeen    <= 1'b0;
      ovf        <= 1'b0;
      lenWr      <= '0;
      lenRd      <= '0;
      dropCnt    <= '0;
    end else begin
      wrState    <= stateNxt;
      wrPtr      <= wrPtrNxt;
      frameStart <= startNxt;
      frmLen     <= lenNxt;
      errSeen    <= errNxt;
      ovf        <= ovfNxt;
      dropCnt    <= satAdd(dropCnt, dropInc);
      if (push)   lenWr <= lenWr + LPTR_ONE;
      if (lenPop) lenRd <= lenRd + LPTR_ONE;
      if (rdEn)   rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage carries no reset; the cleared pointers make old contents unreachable.
  always_ff @(posedge clk125) begin
    if (memWe) mem[memAddr] <= '{data: data};
    if (push)  lenMem[lenWr[LEN_W-1:0]] <= lenNxt;
    if (rdEn)  rdData <= mem[rdPtr[ADDR_W-1:0]].data;
  end

endmodule

// File: rtl/rx_frame_arbiter.sv
// Merges two RGMII receive streams (already in clk125) into one byte stream.
// Each port has a store-and-forward buffer; committed frames are forwarded
// whole, one byte per cycle, chosen by a frame-atomic round-robin arbiter.
// Ports:
//   clk125, rst                              : clock, synchronous active-high reset
//   pN_data/val/err/sof/eof/link_up (N=0,1)  : per-port receive streams
//   out_data/val/sof/eof                     : merged frame stream
//   out_port                                 : source port, held sof..eof
//   drop_cnt0/1                              : saturating dropped-frame counts
module rx_frame_arbiter
  import rx_frame_arbiter_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk125,
  input  logic             rst,
  input  logic [7:0]       p0_data,
  input  logic             p0_val,
  input  logic             p0_err,
  input  logic             p0_sof,
  input  logic             p0_eof,
  input  logic             p0_link_up,
  input  logic [7:0]       p1_data,
  input  logic             p1_val,
  input  logic             p1_err,
  input  logic             p1_sof,
  input  logic             p1_eof,
  input  logic             p1_link_up,
  output logic [7:0]       out_data,
  output logic             out_val,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_port,
  output logic [CNT_W-1:0] drop_cnt0,
  output logic [CNT_W-1:0] drop_cnt1
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [1:0]       rdEn, lenPop;
  logic [PTR_W-1:0] len0, len1, grantLen;
  logic             empty0, empty1;
  logic [7:0]       rdData0, rdData1;

  rx_port_buffer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) uBuf0 (
    .clk125(clk125), .rst(rst),
    .data(p0_data), .val(p0_val), .err(p0_err), .sof(p0_sof), .eof(p0_eof),
    .linkUp(p0_link_up), .rdEn(rdEn[0]), .lenPop(lenPop[0]),
    .len(len0), .empty(empty0), .rdData(rdData0), .dropCnt(drop_cnt0)
  );

  rx_port_buffer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) uBuf1 (
    .clk125(clk125), .rst(rst),
    .data(p1_data), .val(p1_val), .err(p1_err), .sof(p1_sof), .eof(p1_eof),
    .linkUp(p1_link_up), .rdEn(rdEn[1]), .lenPop(lenPop[1]),
    .len(len1), .empty(empty1), .rdData(rdData1), .dropCnt(drop_cnt1)
  );

  arbState_e        arbState, stateNxt;
  logic [PTR_W-1:0] remain, remainNxt;
  logic             curPort, curPortNxt, lastPort, lastNxt, grantPort;
  logic             vld_p0, sof_p0, eof_p0, port_p0;
  logic             vld_p1, sof_p1, eof_p1, port_p1;

  // Stage p0: arbitration and RAM read issue
  always_comb begin
    stateNxt   = arbState;
    remainNxt  = remain;
    curPortNxt = curPort;
    lastNxt    = lastPort;
    rdEn       = 2'b00;
    lenPop     = 2'b00;
    vld_p0     = 1'b0;
    sof_p0     = 1'b0;
    eof_p0     = 1'b0;
    grantPort  = 1'b0;
    grantLen   = len0;
    port_p0    = curPort;
    case (arbState)
      ST_ARB: begin
        if (!empty0 || !empty1) begin
          grantPort         = (!empty0 && !empty1) ? ~lastPort : empty0;
          grantLen          = grantPort ? len1 : len0;
          rdEn[grantPort]   = 1'b1;
          lenPop[grantPort] = 1'b1;
          vld_p0            = 1'b1;
          sof_p0            = 1'b1;
          eof_p0            = (grantLen == PTR_ONE);
          port_p0           = grantPort;
          remainNxt         = grantLen - PTR_ONE;
          curPortNxt        = grantPort;
          lastNxt           = grantPort;
          stateNxt          = ST_SEND;
        end
      end
      default: begin
        // SEND with nothing left is the mandatory idle cycle between frames.
        if (remain == '0) begin
          stateNxt = ST_ARB;
        end else begin
          rdEn[curPort] = 1'b1;
          vld_p0        = 1'b1;
          eof_p0        = (remain == PTR_ONE);
          remainNxt     = remain - PTR_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      arbState <= ST_ARB;
      remain   <= '0;
      curPort  <= 1'b0;
      lastPort <= 1'b1;  // port 0 wins the first tie
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      port_p1  <= 1'b0;
      out_val  <= 1'b0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
      out_port <= 1'b0;
      out_data <= '0;
    end else begin
      arbState <= stateNxt;
      remain   <= remainNxt;
      curPort  <= curPortNxt;
      lastPort <= lastNxt;
      // Stage p1: RAM read data valid
      vld_p1   <= vld_p0;
      sof_p1   <= sof_p0;
      eof_p1   <= eof_p0;
      port_p1  <= port_p0;
      // Stage p2: output register
      out_val  <= vld_p1;
      out_sof  <= vld_p1 & sof_p1;
      out_eof  <= vld_p1 & eof_p1;
      out_data <= vld_p1 ? (port_p1 ? rdData1 : rdData0) : 8'h00;
      if (vld_p1) out_port <= port_p1;
    end
  end

endmodule

// File: tb/tb_rx_frame_arbiter.sv
module tb_rx_frame_arbiter;
  localparam int ADDR_W = 11;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 16;

  logic clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  logic rst;
  logic [7:0] p0_data, p1_data, out_data;
  logic p0_val, p0_err, p0_sof, p0_eof, p0_link_up;
  logic p1_val, p1_err, p1_sof, p1_eof, p1_link_up;
  logic out_val, out_sof, out_eof, out_port;
  logic [CNT_W-1:0] drop_cnt0, drop_cnt1;

  rx_frame_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk125(clk125), .rst(rst),
    .p0_data(p0_data), .p0_val(p0_val), .p0_err(p0_err), .p0_sof(p0_sof),
    .p0_eof(p0_eof), .p0_link_up(p0_link_up),
    .p1_data(p1_data), .p1_val(p1_val), .p1_err(p1_err), .p1_sof(p1_sof),
    .p1_eof(p1_eof), .p1_link_up(p1_link_up),
    .out_data(out_data), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
    .out_port(out_port), .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  always @(posedge clk125) cyc <= cyc + 1;

  // Reference model: frames that must appear, per port, and expected drops.
  logic [7:0] exp0[$], exp1[$];
  int expL0[$], expL1[$];
  int mDrop0 = 0, mDrop1 = 0;
  int eofCyc0 = 0;

  // Output monitor: reassembles frames and flags framing violations.
  logic [7:0] rxData[$], monBytes[$];
  int rxLen[$], rxPort[$], rxSof[$], rxEof[$];
  int monSof = 0, monPort = 0, protoErr = 0;
  bit monIn = 0;

  always @(negedge clk125) begin
    if (rst) begin
      monIn = 0;
      monBytes.delete();
    end else if (out_val) begin
      if (out_sof) begin
        if (monIn) protoErr++;
        monIn = 1; monBytes.delete(); monSof = cyc; monPort = int'(out_port);
      end else if (!monIn) begin
        protoErr++;
      end
      if (monIn) begin
        if (int'(out_port) != monPort) protoErr++;
        monBytes.push_back(out_data);
        if (out_eof) begin
          foreach (monBytes[i]) rxData.push_back(monBytes[i]);
          rxLen.push_back(monBytes.size());
          rxPort.push_back(monPort);
          rxSof.push_back(monSof);
          rxEof.push_back(cyc);
          monIn = 0;
        end
      end
    end else begin
      if (monIn) protoErr++;
      if (out_sof || out_eof || out_data != 8'h00) protoErr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drivePort(input int port, input logic [7:0] d, input logic v,
                           input logic s, input logic e, input logic er, input logic lk);
    if (port == 0) begin
      p0_data = d; p0_val = v; p0_sof = s; p0_eof = e; p0_err = er; p0_link_up = lk;
    end else begin
      p1_data = d; p1_val = v; p1_sof = s; p1_eof = e; p1_err = er; p1_link_up = lk;
    end
  endtask

  // cutAt>=0: stop after cutAt bytes with no eof (next frame follows directly)
  // downAt>=0: link drops from that byte to the end of the frame
  task automatic sendFrame(input int port, input int len, input int errAt,
                           input int cutAt, input int downAt);
    logic [7:0] q[$];
    logic [7:0] d;
    int n;
    bit good;
    n = (cutAt >= 0) ? cutAt : len;
    for (int i = 0; i < n; i++) begin
      @(posedge clk125); #1;
      d = 8'($urandom);
      q.push_back(d);
      drivePort(port, d, 1'b1, i == 0, (cutAt < 0) && (i == len - 1), i == errAt,
                !(downAt >= 0 && i >= downAt));
      if (port == 0 && i == len - 1) eofCyc0 = cyc;
    end
    good = (errAt < 0) && (cutAt < 0) && (downAt < 0) && (len < (1 << ADDR_W));
    if (good) begin
      if (port == 0) begin foreach (q[i]) exp0.push_back(q[i]); expL0.push_back(len); end
      else begin foreach (q[i]) exp1.push_back(q[i]); expL1.push_back(len); end
    end else if (port == 0) mDrop0++;
    else mDrop1++;
    if (cutAt < 0) begin
      @(posedge clk125); #1;
      drivePort(port, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  function automatic int popExpLen(input int p);
    if (p == 0) return (expL0.size() > 0) ? expL0.pop_front() : -1;
    return (expL1.size() > 0) ? expL1.pop_front() : -1;
  endfunction

  function automatic logic [7:0] popExpByte(input int p);
    if (p == 0) return exp0.pop_front();
    return exp1.pop_front();
  endfunction

  task automatic waitDrain();
    int quiet = 0;
    int budget = 0;
    while (quiet < 10 && budget < 20000) begin
      @(negedge clk125);
      quiet = out_val ? 0 : quiet + 1;
      budget++;
    end
    chk("drain_bound", budget < 20000, 1);
  endtask

  task automatic checkDrain(input string tag);
    int l, e, p, nbad;
    logic [7:0] a, b;
    waitDrain();
    while (rxLen.size() > 0) begin
      l = rxLen.pop_front();
      p = rxPort.pop_front();
      a = 8'(rxSof.pop_front() + rxEof.pop_front());
      e = popExpLen(p);
      chk({tag, "_len"}, l, e);
      nbad = 0;
      for (int i = 0; i < ((l > e) ? l : e); i++) begin
        a = (i < l) ? rxData.pop_front() : 8'h00;
        b = (i < e) ? popExpByte(p) : 8'h00;
        if (i >= l || i >= e || a !== b) nbad++;
      end
      chk({tag, "_bytes_bad"}, nbad, 0);
    end
    chk({tag, "_missing0"}, expL0.size(), 0);
    chk({tag, "_missing1"}, expL1.size(), 0);
    chk({tag, "_drop_cnt0"}, drop_cnt0, mDrop0);
    chk({tag, "_drop_cnt1"}, drop_cnt1, mDrop1);
    chk({tag, "_protocol"}, protoErr, 0);
  endtask

  task automatic pulseReset();
    @(posedge clk125); #1 rst = 1'b1;
    @(posedge clk125); #1 rst = 1'b0;
    exp0.delete(); exp1.delete(); expL0.delete(); expL1.delete();
    mDrop0 = 0; mDrop1 = 0;
  endtask

  task automatic randPort(input int port);
    int len, errAt;
    for (int k = 0; k < 10; k++) begin
      len   = $urandom_range(1, 80);
      errAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      sendFrame(port, len, errAt, -1, -1);
      repeat ($urandom_range(len, 2 * len)) @(posedge clk125);
    end
  endtask

  initial begin
    int w;
    int order;
    rst = 1'b1;
    drivePort(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drivePort(1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk125);
    #1 rst = 1'b0;
    @(negedge clk125);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_drop_cnt0", drop_cnt0, 0);
    chk("rst_drop_cnt1", drop_cnt1, 0);

    // 64-byte clean frame on port 0
    sendFrame(0, 64, -1, -1, -1);
    waitDrain();
    chk("t1_frames", rxSof.size(), 1);
    if (rxSof.size() > 0) begin
      chk("t1_latency", rxSof[0], eofCyc0 + 3);
      chk("t1_port", rxPort[0], 0);
    end
    checkDrain("t1");

    // both ports commit two 100-byte frames in the same cycles
    pulseReset();
    fork
      begin sendFrame(0, 100, -1, -1, -1); sendFrame(0, 100, -1, -1, -1); end
      begin sendFrame(1, 100, -1, -1, -1); sendFrame(1, 100, -1, -1, -1); end
    join
    waitDrain();
    chk("t2_frames", rxPort.size(), 4);
    if (rxPort.size() == 4) begin
      order = 1;  // last served after reset, so port 0 goes first
      for (int i = 0; i < 4; i++) begin
        order = 1 - order;
        chk("t2_order", rxPort[i], order);
        if (i < 3) chk("t2_gap", rxSof[i + 1] - rxEof[i], 2);
      end
    end
    checkDrain("t2");

    // port 1: error on byte 10 of 60, then clean 20
    sendFrame(1, 60, 10, -1, -1);
    sendFrame(1, 20, -1, -1, -1);
    checkDrain("t3");

    // 2048-byte frame overflows, then a 1-byte frame
    sendFrame(0, 1 << ADDR_W, -1, -1, -1);
    sendFrame(0, 1, -1, -1, -1);
    checkDrain("t4");

    // unterminated frame cut by sof at byte 30, then 40-byte frame
    sendFrame(0, 70, -1, 30, -1);
    sendFrame(0, 40, -1, -1, -1);
    checkDrain("t5");

    // random traffic on both ports concurrently
    fork
      randPort(0);
      randPort(1);
    join
    checkDrain("rand");

    // link lost at byte 5 of 50
    sendFrame(0, 50, -1, -1, 5);
    checkDrain("t6_link");

    // reset in the middle of an output frame
    sendFrame(1, 50, -1, -1, -1);
    w = 0;
    while (!out_val && w < 200) begin @(negedge clk125); w++; end
    chk("t6_started", w < 200, 1);
    repeat (5) @(posedge clk125);
    pulseReset();
    @(negedge clk125);
    chk("t6_out_val", out_val, 0);
    chk("t6_out_sof", out_sof, 0);
    chk("t6_out_eof", out_eof, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_port", out_port, 0);
    chk("t6_drop_cnt0", drop_cnt0, 0);
    chk("t6_drop_cnt1", drop_cnt1, 0);
    repeat (20) @(posedge clk125);
    sendFrame(0, 10, -1, -1, -1);
    checkDrain("t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
